// File: rtl/bus_host_arbiter.sv
// -----------------------------------------------------------------------------
// bus_host_arbiter
//
// Shares one bus master port between NrHosts requesters. Host 0 is the core
// data port, and the remaining hosts are other masters such as the debug-module
// system-bus host. The winner's request passes straight through to the bus with
// no added cycles. Each accepted request records its host index in an in-order
// ID FIFO. Every response is routed back to the host at the FIFO head, so
// several transactions can be outstanding at once.
//
// Optional feature macro:
//   BUS_ARB_RR_EN  defined   -> round-robin priority starting at the RR pointer
//                  undefined -> fixed priority, lowest host index wins
//
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   host_req_i     [N]   request from each host
//   host_gnt_o     [N]   grant, same cycle as the bus handshake
//   host_addr_i    [N]   request address
//   host_we_i      [N]   write enable
//   host_be_i      [N]   byte enables
//   host_wdata_i   [N]   write data
//   host_rvalid_o  [N]   response valid, routed by the ID FIFO
//   host_rdata_o   [N]   response data (zero for hosts not addressed)
//   host_err_o     [N]   response error
//   dev_req_o .. dev_wdata_o   muxed request to the bus
//   dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i   bus handshake/response
//   outstanding_o        current ID FIFO occupancy
//   orphan_rsp_o         sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module bus_host_arbiter #(
   parameter int NrHosts        = 2,
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int MaxOutstanding = 4
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          host_req_i    [NrHosts],
   output logic                          host_gnt_o    [NrHosts],
   input  logic [AddressWidth-1:0]       host_addr_i   [NrHosts],
   input  logic                          host_we_i     [NrHosts],
   input  logic [DataWidth/8-1:0]        host_be_i     [NrHosts],
   input  logic [DataWidth-1:0]          host_wdata_i  [NrHosts],
   output logic                          host_rvalid_o [NrHosts],
   output logic [DataWidth-1:0]          host_rdata_o  [NrHosts],
   output logic                          host_err_o    [NrHosts],
   output logic                          dev_req_o,
   output logic [AddressWidth-1:0]       dev_addr_o,
   output logic                          dev_we_o,
   output logic [DataWidth/8-1:0]        dev_be_o,
   output logic [DataWidth-1:0]          dev_wdata_o,
   input  logic                          dev_gnt_i,
   input  logic                          dev_rvalid_i,
   input  logic [DataWidth-1:0]          dev_rdata_i,
   input  logic                          dev_err_i,
   output logic [$clog2(MaxOutstanding):0] outstanding_o,
   output logic                          orphan_rsp_o
);

   localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int PtrW = $clog2(MaxOutstanding);
   localparam int CntW = PtrW + 1;

   typedef enum logic {
      LockFree,
      LockHeld
   } lockState_e;

   lockState_e          lockState_q, lockState_d;
   logic [IdxW-1:0]     lockIdx_q, lockIdx_d;
   logic [IdxW-1:0]     idFifo_q [MaxOutstanding];
   logic [PtrW-1:0]     wrPtr_q, wrPtr_d;
   logic [PtrW-1:0]     rdPtr_q, rdPtr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic                orphan_q, orphan_d;
`ifdef BUS_ARB_RR_EN
   logic [IdxW-1:0]     rrPtr_q, rrPtr_d;
   logic [IdxW-1:0]     candIdx;
`endif

   logic                anyReq;
   logic [IdxW-1:0]     freeWinner;
   logic [IdxW-1:0]     winner;
   logic [IdxW-1:0]     headIdx;
   logic                fifoFull;
   logic                fifoEmpty;
   logic                pop;
   logic                devReq;
   logic                handshake;

   // Any host asking for the bus at all.
   always_comb begin
      anyReq = 1'b0;
      for (int i = 0; i < NrHosts; i++) begin
         if (host_req_i[i]) begin
            anyReq = 1'b1;
         end
      end
   end

   // Pick the unlocked winner. Scanning from the far end and overwriting
   // leaves the highest-priority requester in freeWinner.
   always_comb begin
      freeWinner = '0;
`ifdef BUS_ARB_RR_EN
      candIdx = '0;
      for (int k = NrHosts - 1; k >= 0; k--) begin
         candIdx = IdxW'((int'(rrPtr_q) + k) % NrHosts);
         if (host_req_i[candIdx]) begin
            freeWinner = candIdx;
         end
      end
`else
      for (int i = NrHosts - 1; i >= 0; i--) begin
         if (host_req_i[i]) begin
            freeWinner = IdxW'(i);
         end
      end
`endif
   end

   // A pending (locked) request keeps the bus, so its payload cannot change
   // under the slave while it waits for dev_gnt_i.
   always_comb begin
      winner    = (lockState_q == LockHeld) ? lockIdx_q : freeWinner;
      headIdx   = idFifo_q[rdPtr_q];
      fifoFull  = (count_q == CntW'(MaxOutstanding));
      fifoEmpty = (count_q == '0);
      pop       = dev_rvalid_i & ~fifoEmpty;
      // A pop in the same cycle frees a slot, so a full FIFO can still accept.
      // RST_N gating keeps the request quiet while reset is held.
      devReq    = RST_N & anyReq & (~fifoFull | pop);
      handshake = devReq & dev_gnt_i;
   end

   // Request mux toward the bus.
   always_comb begin
      dev_req_o   = devReq;
      dev_addr_o  = host_addr_i[winner];
      dev_we_o    = host_we_i[winner];
      dev_be_o    = host_be_i[winner];
      dev_wdata_o = host_wdata_i[winner];
   end

   // Grant and response fan-out. Hosts other than the selected one see zeros.
   always_comb begin
      for (int i = 0; i < NrHosts; i++) begin
         host_gnt_o[i]    = handshake & (winner == IdxW'(i));
         host_rvalid_o[i] = pop & (headIdx == IdxW'(i));
         host_rdata_o[i]  = host_rvalid_o[i] ? dev_rdata_i : '0;
         host_err_o[i]    = host_rvalid_o[i] & dev_err_i;
      end
   end

   // Lock state machine: it locks when a request is not granted and
   // unlocks on handshake.
   always_comb begin
      lockState_d = lockState_q;
      lockIdx_d   = lockIdx_q;
      case (lockState_q)
         LockFree: begin
            if (devReq && !dev_gnt_i) begin
               lockState_d = LockHeld;
               lockIdx_d   = winner;
            end
         end
         LockHeld: begin
            if (handshake) begin
               lockState_d = LockFree;
            end
         end
         default: lockState_d = LockFree;
      endcase
   end

   // ID FIFO pointers, occupancy counter and sticky orphan flag.
   always_comb begin
      wrPtr_d  = handshake ? wrPtr_q + PtrW'(1) : wrPtr_q;
      rdPtr_d  = pop ? rdPtr_q + PtrW'(1) : rdPtr_q;
      count_d  = count_q;
      case ({handshake, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      orphan_d = orphan_q | (dev_rvalid_i & fifoEmpty);
   end

`ifdef BUS_ARB_RR_EN
   // The round-robin pointer moves just past the host that was served.
   always_comb begin
      rrPtr_d = rrPtr_q;
      if (handshake) begin
         rrPtr_d = IdxW'((int'(winner) + 1) % NrHosts);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rrPtr_q <= '0;
      end else begin
         rrPtr_q <= rrPtr_d;
      end
   end
`endif

   // State registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lockState_q <= LockFree;
         lockIdx_q   <= '0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         orphan_q    <= 1'b0;
      end else begin
         lockState_q <= lockState_d;
         lockIdx_q   <= lockIdx_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         orphan_q    <= orphan_d;
      end
   end

   // ID FIFO storage. It records the winner of every accepted request.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < MaxOutstanding; i++) begin
            idFifo_q[i] <= '0;
         end
      end else if (handshake) begin
         idFifo_q[wrPtr_q] <= winner;
      end
   end

   assign outstanding_o = count_q;
   assign orphan_rsp_o  = orphan_q;

endmodule

// File: tb/tb_bus_host_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_host_arbiter
//
// Self-checking bench for bus_host_arbiter (NrHosts=2, MaxOutstanding=4).
// A queue-based reference model is compared against the DUT on every falling
// edge. Directed scenarios add literal expectations, and then a randomized
// phase drives protocol-respecting hosts. Compile with +define+BUS_ARB_RR_EN
// to exercise the round-robin build.
// -----------------------------------------------------------------------------
module tb_bus_host_arbiter;

   localparam int NrHosts        = 2;
   localparam int DataWidth      = 32;
   localparam int AddressWidth   = 32;
   localparam int MaxOutstanding = 4;
   localparam int CntW           = $clog2(MaxOutstanding) + 1;

   logic                    clk;
   logic                    rstN;
   logic                    hostReq    [NrHosts];
   logic                    hostGnt    [NrHosts];
   logic [AddressWidth-1:0] hostAddr   [NrHosts];
   logic                    hostWe     [NrHosts];
   logic [DataWidth/8-1:0]  hostBe     [NrHosts];
   logic [DataWidth-1:0]    hostWdata  [NrHosts];
   logic                    hostRvalid [NrHosts];
   logic [DataWidth-1:0]    hostRdata  [NrHosts];
   logic                    hostErr    [NrHosts];
   logic                    devReq;
   logic [AddressWidth-1:0] devAddr;
   logic                    devWe;
   logic [DataWidth/8-1:0]  devBe;
   logic [DataWidth-1:0]    devWdata;
   logic                    devGnt;
   logic                    devRvalid;
   logic [DataWidth-1:0]    devRdata;
   logic                    devErr;
   logic [CntW-1:0]         outstanding;
   logic                    orphanRsp;

   int checks;
   int errors;

   // Reference model state
   int  mQueue[$];
   bit  mLocked;
   int  mLockHost;
   int  mPtr;
   bit  mOrphan;
   bit  grantedMask [NrHosts];
   bit  pending     [NrHosts];

   // Per-cycle model expectations
   bit  eAnyReq;
   int  eWinner;
   bit  eFull;
   bit  ePop;
   int  eHead;
   bit  eDevReq;
   bit  eHs;

   bus_host_arbiter #(
      .NrHosts        (NrHosts),
      .DataWidth      (DataWidth),
      .AddressWidth   (AddressWidth),
      .MaxOutstanding (MaxOutstanding)
   ) dut (
      .CLK           (clk),
      .RST_N         (rstN),
      .host_req_i    (hostReq),
      .host_gnt_o    (hostGnt),
      .host_addr_i   (hostAddr),
      .host_we_i     (hostWe),
      .host_be_i     (hostBe),
      .host_wdata_i  (hostWdata),
      .host_rvalid_o (hostRvalid),
      .host_rdata_o  (hostRdata),
      .host_err_o    (hostErr),
      .dev_req_o     (devReq),
      .dev_addr_o    (devAddr),
      .dev_we_o      (devWe),
      .dev_be_o      (devBe),
      .dev_wdata_o   (devWdata),
      .dev_gnt_i     (devGnt),
      .dev_rvalid_i  (devRvalid),
      .dev_rdata_i   (devRdata),
      .dev_err_i     (devErr),
      .outstanding_o (outstanding),
      .orphan_rsp_o  (orphanRsp)
   );

   // 100 MHz free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Highest-priority requester under the active priority scheme.
   function automatic int pickWinner();
      int start;
`ifdef BUS_ARB_RR_EN
      start = mPtr;
`else
      start = 0;
`endif
      for (int k = 0; k < NrHosts; k++) begin
         if (hostReq[(start + k) % NrHosts]) return (start + k) % NrHosts;
      end
      return 0;
   endfunction

   // Compare process: every falling edge, derive what the outputs must be from
   // the model, compare them, then advance the model.
   always @(negedge clk) begin
      if (!rstN) begin
         mQueue.delete();
         mLocked   = 1'b0;
         mLockHost = 0;
         mPtr      = 0;
         mOrphan   = 1'b0;
         checkBit("rstDevReq", devReq, 1'b0);
         checkOutput("rstOutstanding", 32'(outstanding), 32'd0);
         checkBit("rstOrphan", orphanRsp, 1'b0);
         for (int h = 0; h < NrHosts; h++) begin
            grantedMask[h] = 1'b0;
            checkBit("rstGnt", hostGnt[h], 1'b0);
            checkBit("rstRvalid", hostRvalid[h], 1'b0);
         end
      end else begin
         eAnyReq = 1'b0;
         for (int h = 0; h < NrHosts; h++) begin
            if (hostReq[h]) eAnyReq = 1'b1;
         end
         eWinner = mLocked ? mLockHost : pickWinner();
         eFull   = (mQueue.size() == MaxOutstanding);
         ePop    = devRvalid && (mQueue.size() > 0);
         eHead   = ePop ? mQueue[0] : -1;
         eDevReq = eAnyReq && (!eFull || ePop);
         eHs     = eDevReq && devGnt;

         checkBit("devReq", devReq, eDevReq);
         if (eDevReq) begin
            checkOutput("devAddr", devAddr, hostAddr[eWinner]);
            checkBit("devWe", devWe, hostWe[eWinner]);
            checkOutput("devBe", 32'(devBe), 32'(hostBe[eWinner]));
            checkOutput("devWdata", devWdata, hostWdata[eWinner]);
         end
         for (int h = 0; h < NrHosts; h++) begin
            checkBit("hostGnt", hostGnt[h], eHs && (h == eWinner));
            checkBit("hostRvalid", hostRvalid[h], h == eHead);
            checkOutput("hostRdata", hostRdata[h], (h == eHead) ? devRdata : 32'd0);
            checkBit("hostErr", hostErr[h], (h == eHead) && devErr);
         end
         checkOutput("outstanding", 32'(outstanding), 32'(mQueue.size()));
         checkBit("orphan", orphanRsp, mOrphan);

         if (devRvalid && mQueue.size() == 0) mOrphan = 1'b1;
         if (ePop) void'(mQueue.pop_front());
         if (eHs) begin
            mQueue.push_back(eWinner);
            mLocked = 1'b0;
            mPtr    = (eWinner + 1) % NrHosts;
         end else if (eDevReq && !devGnt) begin
            mLocked   = 1'b1;
            mLockHost = eWinner;
         end
         for (int h = 0; h < NrHosts; h++) begin
            grantedMask[h] = eHs && (h == eWinner);
         end
      end
   end

   // One directed cycle: step past the rising edge, drive every input, and
   // settle so that literal checks can follow straight away.
   task automatic applyStimulus(input bit r0, input bit r1, input bit gnt,
                                input bit rv, input logic [31:0] rdata, input bit err);
      @(posedge clk);
      #1;
      hostReq[0] = r0;
      hostReq[1] = r1;
      devGnt     = gnt;
      devRvalid  = rv;
      devRdata   = rdata;
      devErr     = err;
      #1;
   endtask

   task automatic resetDut();
      applyStimulus(0, 0, 0, 0, 32'd0, 0);
      rstN = 1'b0;
      @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   initial begin
      int contExp [4];
      checks = 0;
      errors = 0;
      rstN   = 1'b0;
      for (int h = 0; h < NrHosts; h++) begin
         hostReq[h] = 1'b0;
         pending[h] = 1'b0;
      end
      hostAddr[0]  = 32'h8000_0000;
      hostAddr[1]  = 32'h2000_0010;
      hostWe[0]    = 1'b0;
      hostWe[1]    = 1'b1;
      hostBe[0]    = 4'hF;
      hostBe[1]    = 4'h3;
      hostWdata[0] = 32'h1111_1111;
      hostWdata[1] = 32'h2222_2222;
      devGnt       = 1'b0;
      devRvalid    = 1'b0;
      devRdata     = '0;
      devErr       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstN = 1'b1;
      #1;
      checkOutput("resetOutstanding", 32'(outstanding), 32'd0);
      checkBit("resetDevReq", devReq, 1'b0);
      checkBit("resetOrphan", orphanRsp, 1'b0);

      // Single host read
      applyStimulus(1, 0, 1, 0, 32'd0, 0);
      checkBit("singleGnt0", hostGnt[0], 1'b1);
      checkBit("singleGnt1", hostGnt[1], 1'b0);
      checkOutput("singleAddr", devAddr, 32'h8000_0000);
      applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
      checkBit("singleRvalid0", hostRvalid[0], 1'b1);
      checkOutput("singleRdata0", hostRdata[0], 32'hDEAD_BEEF);
      checkBit("singleRvalid1", hostRvalid[1], 1'b0);
      checkOutput("singleOutstanding", 32'(outstanding), 32'd1);

      // Contention followed by a full FIFO
      resetDut();
`ifdef BUS_ARB_RR_EN
      contExp = '{0, 1, 0, 1};
`else
      contExp = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 1, 0, 32'd0, 0);
         checkBit("contGnt0", hostGnt[0], contExp[i] == 0);
         checkBit("contGnt1", hostGnt[1], contExp[i] == 1);
      end
      applyStimulus(1, 1, 1, 0, 32'd0, 0);
      checkOutput("fullOutstanding", 32'(outstanding), 32'd4);
      checkBit("fullDevReq", devReq, 1'b0);
      checkBit("fullGnt0", hostGnt[0], 1'b0);
      applyStimulus(1, 1, 1, 1, 32'h0000_0055, 0);
      checkBit("fullPushGnt0", hostGnt[0], 1'b1);
      checkBit("fullPopRvalid0", hostRvalid[0], 1'b1);
      checkOutput("fullPopRdata0", hostRdata[0], 32'h0000_0055);
      applyStimulus(0, 0, 0, 0, 32'd0, 0);
      checkOutput("fullStillFour", 32'(outstanding), 32'd4);

      // Lock: host1 waits, host0 arrives late but must not steal the bus
      resetDut();
      applyStimulus(0, 1, 0, 0, 32'd0, 0);
      checkOutput("lockAddr0", devAddr, 32'h2000_0010);
      checkBit("lockNoGnt", hostGnt[1], 1'b0);
      applyStimulus(1, 1, 0, 0, 32'd0, 0);
      checkOutput("lockAddr1", devAddr, 32'h2000_0010);
      applyStimulus(1, 1, 0, 0, 32'd0, 0);
      checkOutput("lockAddr2", devAddr, 32'h2000_0010);
      applyStimulus(1, 1, 1, 0, 32'd0, 0);
      checkBit("lockGnt1", hostGnt[1], 1'b1);
      checkBit("lockGnt0", hostGnt[0], 1'b0);
      applyStimulus(1, 0, 1, 0, 32'd0, 0);
      checkBit("lockThenGnt0", hostGnt[0], 1'b1);

      // In-order routing with an error on the second response
      resetDut();
      applyStimulus(1, 0, 1, 0, 32'd0, 0);
      applyStimulus(0, 1, 1, 0, 32'd0, 0);
      applyStimulus(1, 0, 1, 0, 32'd0, 0);
      applyStimulus(0, 0, 0, 1, 32'd1, 0);
      checkBit("routeRv0a", hostRvalid[0], 1'b1);
      checkOutput("routeData0a", hostRdata[0], 32'd1);
      checkBit("routeRv1a", hostRvalid[1], 1'b0);
      applyStimulus(0, 0, 0, 1, 32'd2, 1);
      checkBit("routeRv1", hostRvalid[1], 1'b1);
      checkOutput("routeData1", hostRdata[1], 32'd2);
      checkBit("routeErr1", hostErr[1], 1'b1);
      checkBit("routeErr0", hostErr[0], 1'b0);
      checkBit("routeRv0b", hostRvalid[0], 1'b0);
      applyStimulus(0, 0, 0, 1, 32'd3, 0);
      checkBit("routeRv0c", hostRvalid[0], 1'b1);
      checkOutput("routeData0c", hostRdata[0], 32'd3);

      // Orphan response, then a reset in the middle of a burst
      applyStimulus(0, 0, 0, 1, 32'h77, 0);
      checkBit("orphanRv0", hostRvalid[0], 1'b0);
      checkBit("orphanRv1", hostRvalid[1], 1'b0);
      applyStimulus(0, 0, 0, 0, 32'd0, 0);
      checkBit("orphanSet", orphanRsp, 1'b1);
      applyStimulus(1, 1, 1, 0, 32'd0, 0);
      applyStimulus(1, 1, 1, 0, 32'd0, 0);
      #1;
      rstN = 1'b0;
      #1;
      checkBit("midRstDevReq", devReq, 1'b0);
      checkBit("midRstGnt0", hostGnt[0], 1'b0);
      checkBit("midRstGnt1", hostGnt[1], 1'b0);
      checkOutput("midRstOutstanding", 32'(outstanding), 32'd0);
      checkBit("midRstOrphan", orphanRsp, 1'b0);
      @(posedge clk);
      #1;
      hostReq[0] = 1'b0;
      hostReq[1] = 1'b0;
      devGnt     = 1'b0;
      rstN       = 1'b1;

      // Randomized traffic: hosts hold requests and payloads until granted.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         for (int h = 0; h < NrHosts; h++) begin
            if (pending[h] && grantedMask[h]) pending[h] = 1'b0;
            if (!pending[h] && $urandom_range(0, 2) == 0) begin
               pending[h]   = 1'b1;
               hostAddr[h]  = $urandom;
               hostWe[h]    = 1'($urandom_range(0, 1));
               hostBe[h]    = 4'($urandom);
               hostWdata[h] = $urandom;
            end
            hostReq[h] = pending[h];
         end
         devGnt    = ($urandom_range(0, 3) != 0);
         devRvalid = ($urandom_range(0, 2) == 0);
         devRdata  = $urandom;
         devErr    = 1'($urandom_range(0, 1));
      end

      applyStimulus(0, 0, 0, 0, 32'd0, 0);
      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
